// File: rtl/sumador_serie_nibble_if.sv
// sumador_serie_nibble_if: request/result bundle for the nibble-serial adder
interface sumador_serie_nibble_if #(parameter int WIDTH = 16);
    logic start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic carry_in;
    logic busy;
    logic done;
    logic [WIDTH-1:0] s;
    logic carry_out;
    modport master (output start, a, b, carry_in, input busy, done, s, carry_out);
    modport slave (input start, a, b, carry_in, output busy, done, s, carry_out);
endinterface

// File: rtl/sumador_serie_nibble.sv
// sumador_serie_nibble: WIDTH-bit adder reusing one 4-bit adder, one nibble per cycle
module sum4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] s,
    output logic       carry_out
);
    assign {carry_out, s} = 5'(a) + 5'(b) + 5'(carry_in);
endmodule

module sumador_serie_nibble #(parameter int WIDTH = 16) (
    input logic clk,
    input logic reset,
    sumador_serie_nibble_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res, res_nx, s_q;
    logic [CW-1:0] cnt;
    logic [3:0] sum_s;
    logic c_ff, co_q, sum_c, last, load;

    sum4 u_sum4 (.a(a_sh[3:0]), .b(b_sh[3:0]), .carry_in(c_ff), .s(sum_s), .carry_out(sum_c));

    assign last = cnt == CW'(NIB - 1);
    assign load = state != ADD && bus.start;
    // each new nibble sum enters at the top, so after NIB steps the result is aligned
    assign res_nx = WIDTH'({sum_s, res} >> 4);
    assign bus.busy = state == ADD;
    assign bus.done = state == DONE;
    assign bus.s = s_q;
    assign bus.carry_out = co_q;

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb begin
        state_nx = state == ADD ? (last ? DONE : ADD) : (bus.start ? ADD : IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh <= '0;
            b_sh <= '0;
            res <= '0;
            c_ff <= 1'b0;
            cnt <= '0;
            s_q <= '0;
            co_q <= 1'b0;
        end else if (load) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            c_ff <= bus.carry_in;
            cnt <= '0;
        end else if (state == ADD) begin
            a_sh <= a_sh >> 4;
            b_sh <= b_sh >> 4;
            res <= res_nx;
            c_ff <= sum_c;
            cnt <= cnt + 1'b1;
            if (last) begin
                s_q <= res_nx;
                co_q <= sum_c;
            end
        end
    end
endmodule

// File: tb/tb_sumador_serie_nibble.sv
// tb_sumador_serie_nibble: randomized and directed checks of the nibble-serial adder at WIDTH 16 and 4
module tb_sumador_serie_nibble;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    sumador_serie_nibble_if #(.WIDTH(16)) if16 ();
    sumador_serie_nibble_if #(.WIDTH(4)) if4 ();
    sumador_serie_nibble #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16));
    sumador_serie_nibble #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));

    always #5 clk = ~clk;

    task automatic wait_done(input bit w4, output int n, output int nb);
        n = 0;
        nb = 0;
        while (!(w4 ? if4.done : if16.done) && n < 20) begin
            nb += int'(w4 ? if4.busy : if16.busy);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci, input string name);
        logic [16:0] exp;
        int n, nb;
        exp = 17'(a) + 17'(b) + 17'(ci);
        @(negedge clk);
        if16.start = 1'b1;
        if16.a = a;
        if16.b = b;
        if16.carry_in = ci;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        wait_done(1'b0, n, nb);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL %s latency: got %0d expected 4", name, n); end
        checks++;
        if (nb !== 4) begin errors++; $display("FAIL %s busy cycles: got %0d expected 4", name, nb); end
        checks++;
        if ({if16.carry_out, if16.s} !== exp) begin
            errors++;
            $display("FAIL %s sum: got %h expected %h", name, {if16.carry_out, if16.s}, exp);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({if16.busy, if16.done, if16.carry_out, if16.s} !== 19'd0) begin
            errors++;
            $display("FAIL reset16: got %h expected 0", {if16.busy, if16.done, if16.carry_out, if16.s});
        end
        checks++;
        if ({if4.busy, if4.done, if4.carry_out, if4.s} !== 7'd0) begin
            errors++;
            $display("FAIL reset4: got %h expected 0", {if4.busy, if4.done, if4.carry_out, if4.s});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed;
        op16(16'h1234, 16'h4321, 1'b0, "dir_5555");
        op16(16'hFFFF, 16'h0001, 1'b0, "dir_ripple");
        op16(16'hFFFF, 16'h0000, 1'b1, "dir_cin_ripple");
        op16(16'h00F0, 16'h0010, 1'b0, "dir_mid_carry");
    endtask

    task automatic test_random;
        for (int i = 0; i < 25; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom), "random");
    endtask

    task automatic test_start_ignored;
        logic [15:0] a, b;
        logic [16:0] exp;
        int n, nb, late;
        a = 16'($urandom);
        b = 16'($urandom);
        exp = 17'(a) + 17'(b) + 17'd1;
        @(negedge clk);
        if16.start = 1'b1;
        if16.a = a;
        if16.b = b;
        if16.carry_in = 1'b1;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        nb = int'(if16.busy);
        @(negedge clk);
        if16.start = 1'b1;
        if16.a = ~a;
        if16.b = b ^ 16'h5A5A;
        if16.carry_in = 1'b0;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        wait_done(1'b0, n, late);
        n += 1;
        nb += late;
        checks++;
        if (n !== 4) begin errors++; $display("FAIL ignored latency: got %0d expected 4", n); end
        checks++;
        if (nb !== 4) begin errors++; $display("FAIL ignored busy cycles: got %0d expected 4", nb); end
        checks++;
        if ({if16.carry_out, if16.s} !== exp) begin
            errors++;
            $display("FAIL ignored sum: got %h expected %h", {if16.carry_out, if16.s}, exp);
        end
        late = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            late += int'(if16.busy | if16.done);
        end
        checks++;
        if (late !== 0) begin errors++; $display("FAIL ignored queued: got %0d active cycles expected 0", late); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] a1, b1, a2, b2;
        logic [16:0] e1, e2;
        int n, nb;
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        a2 = 16'($urandom);
        b2 = 16'($urandom);
        e1 = 17'(a1) + 17'(b1);
        e2 = 17'(a2) + 17'(b2) + 17'd1;
        @(negedge clk);
        if16.start = 1'b1;
        if16.a = a1;
        if16.b = b1;
        if16.carry_in = 1'b0;
        @(posedge clk);
        #1;
        if16.a = a2;
        if16.b = b2;
        if16.carry_in = 1'b1;
        wait_done(1'b0, n, nb);
        checks++;
        if (n !== 4 || {if16.carry_out, if16.s} !== e1) begin
            errors++;
            $display("FAIL b2b first: got lat %0d sum %h expected lat 4 sum %h", n, {if16.carry_out, if16.s}, e1);
        end
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        checks++;
        if (if16.busy !== 1'b1 || {if16.carry_out, if16.s} !== e1) begin
            errors++;
            $display("FAIL b2b hold: got busy %b sum %h expected busy 1 sum %h", if16.busy, {if16.carry_out, if16.s}, e1);
        end
        wait_done(1'b0, n, nb);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL b2b second latency: got %0d expected 4", n); end
        checks++;
        if ({if16.carry_out, if16.s} !== e2) begin
            errors++;
            $display("FAIL b2b second sum: got %h expected %h", {if16.carry_out, if16.s}, e2);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        op16(16'hABCD, 16'h1357, 1'b1, "pre_reset");
        @(negedge clk);
        if16.start = 1'b1;
        if16.a = 16'h8888;
        if16.b = 16'h8888;
        if16.carry_in = 1'b0;
        @(posedge clk);
        #1;
        if16.start = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({if16.busy, if16.done, if16.carry_out, if16.s} !== 19'd0) begin
            errors++;
            $display("FAIL mid reset: got %h expected 0", {if16.busy, if16.done, if16.carry_out, if16.s});
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen += int'(if16.done | if16.busy);
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL post reset activity: got %0d expected 0", seen); end
    endtask

    task automatic test_width4;
        logic [4:0] exp;
        int n, nb, bad;
        bad = 0;
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    exp = 5'(a) + 5'(b) + 5'(c);
                    @(negedge clk);
                    if4.start = 1'b1;
                    if4.a = 4'(a);
                    if4.b = 4'(b);
                    if4.carry_in = 1'(c);
                    @(posedge clk);
                    #1;
                    if4.start = 1'b0;
                    wait_done(1'b1, n, nb);
                    checks++;
                    if (n !== 1 || nb !== 1) begin
                        errors++;
                        $display("FAIL w4 latency %0d+%0d+%0d: got %0d/%0d expected 1/1", a, b, c, n, nb);
                    end
                    checks++;
                    if ({if4.carry_out, if4.s} !== exp) begin
                        errors++;
                        $display("FAIL w4 sum %0d+%0d+%0d: got %h expected %h", a, b, c, {if4.carry_out, if4.s}, exp);
                    end
                end
    endtask

    initial begin
        if16.start = 1'b0;
        if16.a = '0;
        if16.b = '0;
        if16.carry_in = 1'b0;
        if4.start = 1'b0;
        if4.a = '0;
        if4.b = '0;
        if4.carry_in = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
